// File: rtl/spi_slave_frm_if.sv
// Signal bundle between the SPI slave front end and its bus/memory side.
interface spi_slave_frm_if #(
  parameter int DATA_W = 8,
  parameter int CMD_W  = 2
);
  localparam int RX_W = CMD_W + DATA_W;

  logic              SS_n;
  logic              MOSI;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic [RX_W-1:0]   rx_data;
  logic              rx_valid;
  logic              MISO;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output rx_data, rx_valid, MISO, busy, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  rx_data, rx_valid, MISO, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_frm.sv
// SPI slave framer: command/payload deserialiser, read-data serialiser, abort/timeout handling.
// Optional even-parity framing is enabled with `define SPI_SLAVE_PARITY_EN.
module spi_slave_frm #(
  parameter int DATA_W     = 8,
  parameter int CMD_W      = 2,
  parameter int TX_TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_frm_if.slave bus
);
  localparam int RX_W = CMD_W + DATA_W;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int RXL     = RX_W + PAR;
  localparam int TXL     = DATA_W + PAR;
  localparam int LEN_MAX = (RXL > TXL) ? RXL : TXL;
  localparam int CNT_MAX = (LEN_MAX > TX_TIMEOUT) ? LEN_MAX : TX_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RX_LAST = CW'(RXL - 1);
  localparam logic [CW-1:0] RX_END  = CW'(RX_W);
  localparam logic [CW-1:0] TX_END  = CW'(TXL);
  localparam logic [CW-1:0] TO_LAST = CW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADDR, READ_WAIT, READ_DATA
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [RX_W-1:0] rx_data, rx_data_d;
  logic            rx_valid, rx_valid_d;
  logic            miso, miso_d;
  logic            frame_err, frame_err_d;
  logic            read_flag, read_flag_d;
  logic            done, done_d;
  logic            tx_ph, tx_ph_d;
  logic [TXL-1:0]  tx_sh, tx_sh_d, tx_load;
  logic            par_ok;

`ifdef SPI_SLAVE_PARITY_EN
  logic rx_par, rx_par_d;
  assign tx_load = {bus.tx_data, ^bus.tx_data};
  assign par_ok  = ~(rx_par ^ bus.MOSI);
`else
  assign tx_load = bus.tx_data;
  assign par_ok  = 1'b1;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    miso_d      = miso;
    frame_err_d = frame_err;
    read_flag_d = read_flag;
    done_d      = done;
    tx_ph_d     = tx_ph;
    tx_sh_d     = tx_sh;
`ifdef SPI_SLAVE_PARITY_EN
    rx_par_d    = rx_par;
`endif
    unique case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (!bus.SS_n) begin
          state_d     = CHK_CMD;
          frame_err_d = 1'b0;
        end
      end
      CHK_CMD: begin
        cnt_d   = '0;
        done_d  = 1'b0;
        tx_ph_d = 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
        rx_par_d = 1'b0;
`endif
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (!bus.MOSI) begin
          state_d = WRITE;
        end else if (read_flag) begin
          state_d = READ_DATA;
        end else begin
          state_d = READ_ADDR;
        end
      end
      READ_WAIT: begin
        if (bus.SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (bus.tx_valid) begin
          // first bit goes out straight from the load; the register keeps the rest
          miso_d  = tx_load[TXL-1];
          tx_sh_d = tx_load << 1;
          cnt_d   = CW'(1);
          tx_ph_d = 1'b1;
          state_d = READ_DATA;
        end else if (cnt == TO_LAST) begin
          frame_err_d = 1'b1;
          read_flag_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WRITE, READ_ADDR, READ_DATA: begin
        if (bus.SS_n) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if (!done) begin
            frame_err_d = 1'b1;
            if (tx_ph) read_flag_d = 1'b0;
          end
        end else if (done) begin
          state_d = state;
        end else if (tx_ph) begin
          if (cnt == TX_END) begin
            miso_d      = 1'b0;
            read_flag_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            miso_d  = tx_sh[TXL-1];
            tx_sh_d = tx_sh << 1;
            cnt_d   = cnt + 1'b1;
          end
        end else begin
          if (cnt < RX_END) begin
            rx_data_d = {rx_data[RX_W-2:0], bus.MOSI};
`ifdef SPI_SLAVE_PARITY_EN
            rx_par_d  = rx_par ^ bus.MOSI;
`endif
          end
          cnt_d = cnt + 1'b1;
          if (cnt == RX_LAST) begin
            if (par_ok) begin
              rx_valid_d = 1'b1;
              if (state == READ_ADDR) read_flag_d = 1'b1;
              if (state == READ_DATA) begin
                state_d = READ_WAIT;
                cnt_d   = '0;
              end else begin
                done_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              done_d      = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
      frame_err <= 1'b0;
      read_flag <= 1'b0;
      done      <= 1'b0;
      tx_ph     <= 1'b0;
      tx_sh     <= '0;
`ifdef SPI_SLAVE_PARITY_EN
      rx_par    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      miso      <= miso_d;
      frame_err <= frame_err_d;
      read_flag <= read_flag_d;
      done      <= done_d;
      tx_ph     <= tx_ph_d;
      tx_sh     <= tx_sh_d;
`ifdef SPI_SLAVE_PARITY_EN
      rx_par    <= rx_par_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.MISO      = miso;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_spi_slave_frm.sv
// Self-checking bench for spi_slave_frm: directed frames plus randomized transactions vs a frame-level model.
module tb_spi_slave_frm;
  localparam int DATA_W     = 8;
  localparam int CMD_W      = 2;
  localparam int TX_TIMEOUT = 15;
  localparam int RX_W       = CMD_W + DATA_W;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int RXL = RX_W + PAR;
  localparam int TXL = DATA_W + PAR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // frame-level model: read pointer flag, sticky error, last received word
  bit              m_rf;
  bit              m_ferr;
  logic [RX_W-1:0] m_rx;

  spi_slave_frm_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

  spi_slave_frm #(.DATA_W(DATA_W), .CMD_W(CMD_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_ss();
    bus.SS_n = 1'b1;
    tick();
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_ferr", bus.frame_err, m_ferr);
    check_eq("idle_miso", bus.MISO, 0);
    tick();
  endtask

  task automatic tx_abort();
    bus.SS_n = 1'b1;
    tick();
    m_ferr = 1;
    m_rf   = 0;
    check_eq("txab_busy", bus.busy, 0);
    check_eq("txab_ferr", bus.frame_err, 1);
    check_eq("txab_miso", bus.MISO, 0);
    tick();
  endtask

  task automatic transaction(input bit cmd, input logic [RX_W-1:0] bits, input int abort_at,
                             input bit bad_par, input int d, input logic [DATA_W-1:0] v,
                             input int abort_tx, input int rst_at);
    bit             rf0;
    int             k;
    logic [TXL-1:0] txw;
    rf0 = m_rf;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    bus.tx_valid = 1'b0;
    tick();
    check_eq("start_busy", bus.busy, 1);
    check_eq("start_ferr", bus.frame_err, 0);
    m_ferr = 0;
    bus.MOSI = cmd;
    tick();
    check_eq("cmd_busy", bus.busy, 1);
    for (int i = 0; i < RXL; i++) begin
      if (i == abort_at) begin
        k = (i < RX_W) ? i : RX_W;
        m_rx = (k == RX_W) ? bits : ((m_rx << k) | (bits >> (RX_W - k)));
        bus.SS_n = 1'b1;
        tick();
        m_ferr = 1;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_ferr", bus.frame_err, 1);
        check_eq("abort_rxv", bus.rx_valid, 0);
        check_eq("abort_rxd", bus.rx_data, m_rx);
        tick();
        return;
      end
      if (i < RX_W) bus.MOSI = bits[RX_W-1-i];
      else bus.MOSI = (^bits) ^ bad_par;
      tick();
      if (i < RXL - 1) begin
        check_eq("rx_early_rxv", bus.rx_valid, 0);
        check_eq("rx_busy", bus.busy, 1);
      end
    end
    m_rx = bits;
    if (bad_par) begin
      m_ferr = 1;
      check_eq("par_rxv", bus.rx_valid, 0);
      check_eq("par_ferr", bus.frame_err, 1);
      release_ss();
      return;
    end
    check_eq("strobe_rxv", bus.rx_valid, 1);
    check_eq("strobe_rxd", bus.rx_data, bits);
    if (cmd == 1'b0 || !rf0) begin
      if (cmd) m_rf = 1;
      // tx_valid must be ignored outside READ_WAIT
      bus.tx_valid = 1'b1;
      bus.tx_data  = DATA_W'($urandom) | DATA_W'(1);
      repeat (3) begin
        tick();
        check_eq("hold_rxv", bus.rx_valid, 0);
        check_eq("hold_miso", bus.MISO, 0);
        check_eq("hold_busy", bus.busy, 1);
      end
      bus.tx_valid = 1'b0;
      release_ss();
      return;
    end
    if (d >= TX_TIMEOUT) begin
      repeat (TX_TIMEOUT - 1) begin
        tick();
        check_eq("wait_busy", bus.busy, 1);
        check_eq("wait_rxv", bus.rx_valid, 0);
      end
      tick();
      check_eq("to_busy", bus.busy, 0);
      check_eq("to_ferr", bus.frame_err, 1);
      check_eq("to_rxv", bus.rx_valid, 0);
      m_ferr = 1;
      m_rf   = 0;
      bus.SS_n = 1'b1;
      tick();
      tick();
      return;
    end
    repeat (d) begin
      tick();
      check_eq("wait_busy", bus.busy, 1);
      check_eq("wait_miso", bus.MISO, 0);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = v;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = DATA_W'($urandom);
`ifdef SPI_SLAVE_PARITY_EN
    txw = {v, ^v};
`else
    txw = v;
`endif
    for (int j = 0; j < TXL; j++) begin
      if (j > 0) begin
        if (j == abort_tx) begin
          tx_abort();
          return;
        end
        tick();
      end
      check_eq("miso_bit", bus.MISO, txw[TXL-1-j]);
      if (j == rst_at) begin
        rst_n = 1'b0;
        tick();
        check_eq("rst_rxd", bus.rx_data, 0);
        check_eq("rst_rxv", bus.rx_valid, 0);
        check_eq("rst_miso", bus.MISO, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_ferr", bus.frame_err, 0);
        rst_n = 1'b1;
        bus.SS_n = 1'b1;
        m_rf = 0;
        m_ferr = 0;
        m_rx = '0;
        tick();
        tick();
        return;
      end
    end
    if (abort_tx == TXL) begin
      tx_abort();
      return;
    end
    tick();
    m_rf = 0;
    check_eq("tx_end_miso", bus.MISO, 0);
    check_eq("tx_end_busy", bus.busy, 1);
    release_ss();
  endtask

  initial begin
    bit              cmd;
    bit              bad;
    int              kind;
    int              ab;
    int              d;
    int              atx;
    logic [RX_W-1:0] bits;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    m_rf   = 0;
    m_ferr = 0;
    m_rx   = '0;

    tick();
    tick();
    check_eq("reset_rxd", bus.rx_data, 0);
    check_eq("reset_rxv", bus.rx_valid, 0);
    check_eq("reset_miso", bus.MISO, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_ferr", bus.frame_err, 0);
    rst_n = 1'b1;
    tick();

    transaction(1'b0, 10'h0A5, -1, 1'b0, 0, 8'h00, 0, -1);
    transaction(1'b1, 10'h233, -1, 1'b0, 0, 8'h00, 0, -1);
    transaction(1'b1, 10'h300, -1, 1'b0, 3, 8'hC3, 0, -1);
    transaction(1'b1, 10'h155, -1, 1'b0, 0, 8'h00, 0, -1);
    transaction(1'b1, 10'h3FF, -1, 1'b0, TX_TIMEOUT + 1, 8'h00, 0, -1);
    transaction(1'b1, 10'h0F0, -1, 1'b0, 0, 8'h00, 0, -1);
    transaction(1'b1, 10'h30F, -1, 1'b0, 1, 8'h5A, 0, 3);
    transaction(1'b1, 10'h111, -1, 1'b0, 0, 8'h00, 0, -1);
    transaction(1'b0, 10'h2AA, 5, 1'b0, 0, 8'h00, 0, -1);
    transaction(1'b0, 10'h1C3, -1, 1'b0, 0, 8'h00, 0, -1);
`ifdef SPI_SLAVE_PARITY_EN
    transaction(1'b0, 10'h0A5, -1, 1'b1, 0, 8'h00, 0, -1);
`endif

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 3));
      bits = RX_W'($urandom);
      cmd  = (kind != 0);
      ab   = -1;
      if (kind == 3) begin
        cmd = 1'($urandom_range(0, 1));
        ab  = int'($urandom_range(0, RXL - 1));
      end
      bad = (PAR != 0) && ($urandom_range(0, 5) == 0);
      d   = ($urandom_range(0, 5) == 0) ? TX_TIMEOUT + 2 : int'($urandom_range(0, 6));
      atx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, TXL)) : 0;
      transaction(cmd, bits, ab, bad, d, DATA_W'($urandom), atx, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
